// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port among three requesters:
// the single-cycle ALU/load writeback path, a buffered MDU result stream
// and a debug write port. Fixed priority is starved MDU > ALU > MDU > DBG.
// A starvation counter stalls the ALU once the MDU FIFO head has waited
// STARVE_MAX cycles.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   alu_wr/alu_wa/alu_wd      ALU writeback request (held while alu_stall)
//   alu_stall                 ALU request not accepted this cycle
//   mdu_valid/mdu_wa/mdu_wd   MDU result push into the FIFO
//   mdu_ready                 FIFO not full
//   dbg_req/dbg_wa/dbg_wd     debug write request, held until dbg_ack
//   dbg_ack                   pulses with the cycle rf_wr carries the debug write
//   rf_wr/rf_wa/rf_wd         registered register-file write port
//   pend_mask                 registers with an accepted, not yet issued write
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        alu_wr,
   input  logic [4:0]  alu_wa,
   input  logic [31:0] alu_wd,
   output logic        alu_stall,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_wa,
   input  logic [31:0] mdu_wd,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_wa,
   input  logic [31:0] dbg_wd,
   output logic        dbg_ack,
   output logic        rf_wr,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [31:0] pend_mask
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MDU, GNT_DBG} grant_e;

   // FIFO storage and pointers
   logic [4:0]    r_fifo_wa [DEPTH];
   logic [31:0]   r_fifo_wd [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic [SW-1:0] r_starve;
   logic          r_rf_wr;
   logic [4:0]    r_rf_wa;
   logic [31:0]   r_rf_wd;
   logic          r_dbg_ack;

   logic          w_empty;
   logic          w_full;
   logic          w_stall;
   logic          w_push;
   logic          w_pop;
   grant_e        w_grant;
   logic [4:0]    w_gnt_wa;
   logic [31:0]   w_gnt_wd;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   // Stall depends only on registered state, never on alu_wr.
   assign w_stall = (r_starve == SW'(STARVE_MAX)) && !w_empty;
   // Readiness uses current occupancy only: a pop this cycle frees no slot yet.
   assign w_push  = mdu_valid && !w_full;
   assign w_pop   = (w_grant == GNT_MDU);

   // Grant selection
   always_comb begin
      // NOTE: every signal gets a default before the if-chain so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_grant  = GNT_NONE;
      w_gnt_wa = '0;
      w_gnt_wd = '0;
      if (w_stall) begin
         w_grant = GNT_MDU;
      end else if (alu_wr) begin
         w_grant = GNT_ALU;
      end else if (!w_empty) begin
         w_grant = GNT_MDU;
      end else if (dbg_req && !r_dbg_ack) begin
         // A request still held during its ack cycle must not be served twice.
         w_grant = GNT_DBG;
      end
      case (w_grant)
         GNT_ALU: begin
            w_gnt_wa = alu_wa;
            w_gnt_wd = alu_wd;
         end
         GNT_MDU: begin
            w_gnt_wa = r_fifo_wa[r_rd_ptr];
            w_gnt_wd = r_fifo_wd[r_rd_ptr];
         end
         GNT_DBG: begin
            w_gnt_wa = dbg_wa;
            w_gnt_wd = dbg_wd;
         end
         default: ;
      endcase
   end

   // NOTE: FIFO storage has no reset; validity is tracked by r_count alone, so
   // clearing the data array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_wa[r_wr_ptr] <= mdu_wa;
         r_fifo_wd[r_wr_ptr] <= mdu_wd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_starve  <= '0;
         r_rf_wr   <= 1'b0;
         r_rf_wa   <= '0;
         r_rf_wd   <= '0;
         r_dbg_ack <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);

         if (w_empty || w_pop) begin
            r_starve <= '0;
         end else if (r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
         end

         // Register 0 completes the handshake but never writes.
         if (w_grant != GNT_NONE) begin
            r_rf_wr <= (w_gnt_wa != 5'd0);
            r_rf_wa <= w_gnt_wa;
            r_rf_wd <= w_gnt_wd;
         end else begin
            r_rf_wr <= 1'b0;
         end
         r_dbg_ack <= (w_grant == GNT_DBG);
      end
   end

   // Pending mask: every valid FIFO entry plus the write currently on rf_wr.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            pend_mask[r_fifo_wa[r_rd_ptr + PW'(i)]] = 1'b1;
         end
      end
      if (r_rf_wr) pend_mask[r_rf_wa] = 1'b1;
      pend_mask[0] = 1'b0;
   end

   assign alu_stall = w_stall;
   assign mdu_ready = !w_full;
   assign dbg_ack   = r_dbg_ack;
   assign rf_wr     = r_rf_wr;
   assign rf_wa     = r_rf_wa;
   assign rf_wd     = r_rf_wd;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed stimulus against rf_wb_arbiter. A queue-based reference model
// predicts all outputs every cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alu_wr = 1'b0;
   logic [4:0]  alu_wa = '0;
   logic [31:0] alu_wd = '0;
   logic        alu_stall;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_wa = '0;
   logic [31:0] mdu_wd = '0;
   logic        dbg_req = 1'b0;
   logic [4:0]  dbg_wa = '0;
   logic [31:0] dbg_wd = '0;
   logic        dbg_ack;
   logic        rf_wr;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] pend_mask;

   int errors = 0;
   int checks = 0;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rstn(rstn),
      .alu_wr(alu_wr), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_stall(alu_stall),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
      .dbg_req(dbg_req), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd), .dbg_ack(dbg_ack),
      .rf_wr(rf_wr), .rf_wa(rf_wa), .rf_wd(rf_wd), .pend_mask(pend_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } ent_t;

   ent_t        q[$];
   int          m_starve  = 0;
   logic        e_rf_wr   = 1'b0;
   logic [4:0]  e_rf_wa   = '0;
   logic [31:0] e_rf_wd   = '0;
   logic        e_dbg_ack = 1'b0;

   function automatic logic [31:0] model_pend();
      logic [31:0] m = '0;
      foreach (q[i]) m[q[i].wa] = 1'b1;
      if (e_rf_wr) m[e_rf_wa] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   always @(posedge clk or negedge rstn) begin : model
      int          n;
      int          g;   // 0 none, 1 alu, 2 mdu, 3 dbg
      logic [4:0]  wa;
      logic [31:0] wd;
      if (!rstn) begin
         q.delete();
         m_starve  <= 0;
         e_rf_wr   <= 1'b0;
         e_rf_wa   <= '0;
         e_rf_wd   <= '0;
         e_dbg_ack <= 1'b0;
      end else begin
         n  = q.size();
         wa = '0;
         wd = '0;
         if (m_starve == STARVE_MAX && n > 0) g = 2;
         else if (alu_wr)                     g = 1;
         else if (n > 0)                      g = 2;
         else if (dbg_req && !e_dbg_ack)      g = 3;
         else                                 g = 0;
         if (g == 1) begin wa = alu_wa;  wd = alu_wd;  end
         if (g == 2) begin wa = q[0].wa; wd = q[0].wd; end
         if (g == 3) begin wa = dbg_wa;  wd = dbg_wd;  end
         if (g != 0) begin
            e_rf_wr <= (wa != 0);
            e_rf_wa <= wa;
            e_rf_wd <= wd;
         end else begin
            e_rf_wr <= 1'b0;
         end
         e_dbg_ack <= (g == 3);
         if (g == 2 || n == 0)        m_starve <= 0;
         else if (m_starve < STARVE_MAX) m_starve <= m_starve + 1;
         if (g == 2) void'(q.pop_front());
         if (mdu_valid && n < DEPTH) q.push_back({mdu_wa, mdu_wd});
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("rf_wr",     {31'd0, rf_wr},     {31'd0, e_rf_wr});
      check("rf_wa",     {27'd0, rf_wa},     {27'd0, e_rf_wa});
      check("rf_wd",     rf_wd,              e_rf_wd);
      check("dbg_ack",   {31'd0, dbg_ack},   {31'd0, e_dbg_ack});
      check("mdu_ready", {31'd0, mdu_ready}, {31'd0, (q.size() < DEPTH)});
      check("alu_stall", {31'd0, alu_stall},
            {31'd0, (m_starve == STARVE_MAX && q.size() > 0)});
      check("pend_mask", pend_mask, model_pend());
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_wr = 1'b0; mdu_valid = 1'b0; dbg_req = 1'b0;
   endtask

   initial begin
      int ack_cnt;
      int wr12_cnt;
      rstn = 1'b0;
      tick();
      tick();
      check("reset rf_wr",     {31'd0, rf_wr},     32'd0);
      check("reset mdu_ready", {31'd0, mdu_ready}, 32'd1);
      check("reset alu_stall", {31'd0, alu_stall}, 32'd0);
      check("reset pend_mask", pend_mask,          32'd0);
      rstn = 1'b1;
      tick();

      // ALU only
      alu_wr = 1'b1; alu_wa = 5'd5; alu_wd = 32'h1234;
      check("alu stall n", {31'd0, alu_stall}, 32'd0);
      tick();
      check("alu rf_wr", {31'd0, rf_wr}, 32'd1);
      check("alu rf_wa", {27'd0, rf_wa}, 32'd5);
      check("alu rf_wd", rf_wd,          32'h1234);
      alu_wr = 1'b0;
      tick();
      check("alu idle rf_wr", {31'd0, rf_wr}, 32'd0);
      check("alu hold rf_wa", {27'd0, rf_wa}, 32'd5);

      // MDU queue order
      mdu_valid = 1'b1; mdu_wa = 5'd3; mdu_wd = 32'hA;
      tick();
      mdu_wa = 5'd7; mdu_wd = 32'hB;
      tick();
      mdu_valid = 1'b0;
      check("mdu1 rf_wa", {27'd0, rf_wa}, 32'd3);
      check("mdu1 rf_wd", rf_wd,          32'hA);
      check("mdu1 pend",  pend_mask,      32'h88);
      tick();
      check("mdu2 rf_wa", {27'd0, rf_wa}, 32'd7);
      check("mdu2 rf_wd", rf_wd,          32'hB);
      check("mdu2 pend",  pend_mask,      32'h80);
      tick();
      check("mdu3 pend",  pend_mask,      32'h0);
      check("mdu3 rf_wr", {31'd0, rf_wr}, 32'd0);

      // Starvation: head (9,0xC) waits 4 cycles, stall in the 5th
      alu_wr = 1'b1; alu_wa = 5'd1; alu_wd = 32'h100;
      mdu_valid = 1'b1; mdu_wa = 5'd9; mdu_wd = 32'hC;
      tick();
      mdu_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check("starve no stall", {31'd0, alu_stall}, 32'd0);
         check("starve alu wd",   rf_wd, 32'h100 + 32'(k - 1));
         alu_wd = 32'h100 + 32'(k);
         tick();
      end
      check("starve stall",  {31'd0, alu_stall}, 32'd1);
      check("starve alu wd", rf_wd, 32'h104);
      alu_wd = 32'h105;
      tick();
      check("starve mdu rf_wa", {27'd0, rf_wa}, 32'd9);
      check("starve mdu rf_wd", rf_wd,          32'hC);
      check("starve released",  {31'd0, alu_stall}, 32'd0);
      tick();
      check("starve held rf_wa", {27'd0, rf_wa}, 32'd1);
      check("starve held rf_wd", rf_wd,          32'h105);
      alu_wr = 1'b0;
      tick();

      // Full FIFO and register 0
      alu_wr = 1'b1; alu_wa = 5'd2; alu_wd = 32'h200;
      mdu_valid = 1'b1; mdu_wa = 5'd0; mdu_wd = 32'h55;
      tick();
      mdu_wa = 5'd4; mdu_wd = 32'h44;
      tick();
      check("full ready",   {31'd0, mdu_ready}, 32'd0);
      check("full pend r0", pend_mask, 32'h10 | 32'h4);
      mdu_wa = 5'd6; mdu_wd = 32'h66;
      tick();
      check("full still", {31'd0, mdu_ready}, 32'd0);
      alu_wr = 1'b0;
      tick();
      check("r0 no write",     {31'd0, rf_wr},     32'd0);
      check("pop no push",     {31'd0, mdu_ready}, 32'd1);
      check("r0 popped pend",  pend_mask,          32'h10);
      tick();
      mdu_valid = 1'b0;
      check("wrap rf_wa", {27'd0, rf_wa}, 32'd4);
      check("wrap pend",  pend_mask,      32'h50);
      tick();
      check("wrap2 rf_wa", {27'd0, rf_wa}, 32'd6);
      check("wrap2 rf_wd", rf_wd,          32'h66);
      tick();

      // Debug behind a 3-cycle ALU burst
      ack_cnt = 0; wr12_cnt = 0;
      dbg_req = 1'b1; dbg_wa = 5'd12; dbg_wd = 32'hDEAD;
      alu_wr = 1'b1; alu_wa = 5'd8; alu_wd = 32'h800;
      for (int k = 1; k <= 6; k++) begin
         tick();
         ack_cnt  += int'(dbg_ack);
         wr12_cnt += int'(rf_wr && rf_wa == 5'd12);
         if (k <= 3) check("dbg wait ack", {31'd0, dbg_ack}, 32'd0);
         if (k == 3) alu_wr = 1'b0;
         if (k == 4) begin
            check("dbg ack",   {31'd0, dbg_ack}, 32'd1);
            check("dbg rf_wa", {27'd0, rf_wa},   32'd12);
            check("dbg rf_wd", rf_wd,            32'hDEAD);
         end
         if (k == 5) begin
            check("dbg no reissue", {31'd0, rf_wr}, 32'd0);
            dbg_req = 1'b0;
         end
      end
      check("dbg ack pulses", 32'(ack_cnt),  32'd1);
      check("dbg writes",     32'(wr12_cnt), 32'd1);

      // Reset mid-traffic with two buffered MDU results
      alu_wr = 1'b1; alu_wa = 5'd3; alu_wd = 32'h1;
      mdu_valid = 1'b1; mdu_wa = 5'd10; mdu_wd = 32'hA0;
      tick();
      mdu_wa = 5'd11; mdu_wd = 32'hB0;
      tick();
      mdu_valid = 1'b0;
      check("pre-reset pend", pend_mask, 32'hC08);
      #2 rstn = 1'b0;
      #1;
      check("async rf_wr",     {31'd0, rf_wr},     32'd0);
      check("async mdu_ready", {31'd0, mdu_ready}, 32'd1);
      check("async pend",      pend_mask,          32'd0);
      idle_inputs();
      tick();
      tick();
      rstn = 1'b1;
      tick();
      check("post-reset rf_wr", {31'd0, rf_wr}, 32'd0);
      tick();
      check("post-reset rf_wr2", {31'd0, rf_wr}, 32'd0);
      check("post-reset pend",   pend_mask,      32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
